// File: rtl/cordic_pkg.sv
// Shared definitions for the hyperbolic CORDIC engine: widths, repeat indices,
// FSM states and the elaboration-time atanh table generator.
package cordic_pkg;

  localparam int I_FRA_WIDTH = 16;
  localparam int I_INT_WIDTH = 3;
  localparam int IDWIDTH     = 1 + I_INT_WIDTH + I_FRA_WIDTH;

  localparam int NREP = 3;
  localparam int REP_IDX [NREP] = '{4, 13, 40};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic is_rep(input int i);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NREP; k++)
      if (REP_IDX[k] == i) r = 1'b1;
    return r;
  endfunction

  function automatic int nstep(input int iter);
    int n;
    n = iter;
    for (int k = 0; k < NREP; k++)
      if (REP_IDX[k] <= iter) n = n + 1;
    return n;
  endfunction

  // atanh(2^-i) = sum x^(2k+1)/(2k+1), evaluated with 100 fraction bits, then
  // rounded to fra bits. Only ever evaluated as a constant.
  function automatic logic [63:0] atanh_lut(input int i, input int fra);
    logic [127:0] acc;
    logic [127:0] term;
    int           e;
    acc = '0;
    if (i <= 0) return '0;
    for (int k = 0; k < 64; k++) begin
      e = 100 - i * (2 * k + 1);
      if (e >= 0) begin
        term = (128'd1 << e) / 128'(2 * k + 1);
        acc  = acc + term;
      end
    end
    acc = (acc + (128'd1 << (99 - fra))) >> (100 - fra);
    return acc[63:0];
  endfunction

endpackage

// File: rtl/hyp_microrot.sv
// One hyperbolic micro-rotation: purely combinational, direction taken from the
// sign of the current residual angle.
module hyp_microrot
  import cordic_pkg::*;
#(
  parameter int DWIDTH    = IDWIDTH,
  parameter int FRA_WIDTH = I_FRA_WIDTH,
  parameter int IDXW      = 5
) (
  input  logic [DWIDTH-1:0] x,
  input  logic [DWIDTH-1:0] y,
  input  logic [DWIDTH-1:0] z,
  input  logic [IDXW-1:0]   idx,
  output logic [DWIDTH-1:0] xn,
  output logic [DWIDTH-1:0] yn,
  output logic [DWIDTH-1:0] zn
);

  logic [DWIDTH-1:0] lut [2**IDXW];
  logic [DWIDTH-1:0] xs;
  logic [DWIDTH-1:0] ys;
  logic              neg;

  for (genvar g = 0; g < 2**IDXW; g++) begin : g_lut
    assign lut[g] = DWIDTH'(atanh_lut(g, FRA_WIDTH));
  end

  assign xs  = DWIDTH'($signed(x) >>> idx);
  assign ys  = DWIDTH'($signed(y) >>> idx);
  assign neg = z[DWIDTH-1];

  always_comb begin
    xn = x + ys;
    yn = y + xs;
    zn = z - lut[idx];
    if (neg) begin
      xn = x - ys;
      yn = y - xs;
      zn = z + lut[idx];
    end
  end

endmodule

// File: rtl/hyp_cordic_iter.sv
// Iterative hyperbolic CORDIC rotator: one micro-rotation per cycle over a shared
// datapath, with repeated indices 4/13/40 and valid/ready on both sides.
module hyp_cordic_iter
  import cordic_pkg::*;
#(
  parameter int FRA_WIDTH = I_FRA_WIDTH,
  parameter int INT_WIDTH = I_INT_WIDTH,
  parameter int DWIDTH    = IDWIDTH,
  parameter int ITER      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] Xin,
  input  logic [DWIDTH-1:0] Yin,
  input  logic [DWIDTH-1:0] Zin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] Xout,
  output logic [DWIDTH-1:0] Yout,
  output logic [DWIDTH-1:0] Zout
);

  localparam int IDXW  = $clog2(ITER + 1);
  localparam int NSTEP = nstep(ITER);
  localparam int SW    = $clog2(NSTEP);

  if (DWIDTH != 1 + INT_WIDTH + FRA_WIDTH || ITER < 5 || ITER > DWIDTH - 1) begin : g_param_check
    $error("hyp_cordic_iter: inconsistent width or ITER parameters");
  end

  state_t            state;
  logic [SW-1:0]     step;
  logic [IDXW-1:0]   idx;
  logic              rep;
  logic [DWIDTH-1:0] xr;
  logic [DWIDTH-1:0] yr;
  logic [DWIDTH-1:0] zr;
  logic [DWIDTH-1:0] xn;
  logic [DWIDTH-1:0] yn;
  logic [DWIDTH-1:0] zn;

  hyp_microrot #(
    .DWIDTH   (DWIDTH),
    .FRA_WIDTH(FRA_WIDTH),
    .IDXW     (IDXW)
  ) u_microrot (
    .x  (xr),
    .y  (yr),
    .z  (zr),
    .idx(idx),
    .xn (xn),
    .yn (yn),
    .zn (zn)
  );

  // step counts micro-rotations so the end of BUSY does not depend on idx decoding
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      xr        <= '0;
      yr        <= '0;
      zr        <= '0;
      step      <= '0;
      idx       <= '0;
      rep       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            xr       <= Xin;
            yr       <= Yin;
            zr       <= Zin;
            step     <= '0;
            idx      <= IDXW'(1);
            rep      <= 1'b0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          xr   <= xn;
          yr   <= yn;
          zr   <= zn;
          step <= step + 1'b1;
          if (is_rep(int'(idx)) && !rep) begin
            rep <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
            rep <= 1'b0;
          end
          if (step == SW'(NSTEP - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign Xout = xr;
  assign Yout = yr;
  assign Zout = zr;

endmodule

// File: tb/tb_hyp_cordic_iter.sv
// Self-checking bench for hyp_cordic_iter: scoreboard of bit-exact model results,
// plus latency, throughput, backpressure, reset-abort and index-sequence checks.
module tb_hyp_cordic_iter;

  typedef struct {
    logic [19:0] x;
    logic [19:0] y;
    logic [19:0] z;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [19:0] Xin = '0;
  logic [19:0] Yin = '0;
  logic [19:0] Zin = '0;
  logic        in_ready;
  logic        out_valid;
  logic [19:0] Xout;
  logic [19:0] Yout;
  logic [19:0] Zout;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   prev_acc = 0;
  int   idx_log[$];
  int   exp_seq[$];
  exp_t sb[$];

  logic [19:0] ox;
  logic [19:0] oy;
  logic [19:0] oz;

  hyp_cordic_iter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Xin      (Xin),
    .Yin      (Yin),
    .Zin      (Zin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Xout     (Xout),
    .Yout     (Yout),
    .Zout     (Zout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [19:0] obs, input logic [19:0] ref_v, input int tol);
    logic signed [19:0] d;
    logic               ok;
    d  = obs - ref_v;
    ok = (int'(d) <= tol) && (int'(d) >= -tol);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h +/-%0d", tag, obs, ref_v, tol);
    end
  endtask

  function automatic logic [19:0] tb_atanh(input int i);
    real r;
    r = $atanh(2.0 ** (-i)) * 65536.0;
    return 20'($rtoi(r + 0.5));
  endfunction

  function automatic exp_t model(input logic [19:0] x0, input logic [19:0] y0,
                                 input logic [19:0] z0, input string tag);
    logic signed [19:0] x, y, z, xs, ys, a;
    exp_t e;
    x = x0; y = y0; z = z0;
    foreach (exp_seq[n]) begin
      xs = x >>> exp_seq[n];
      ys = y >>> exp_seq[n];
      a  = tb_atanh(exp_seq[n]);
      if (z < 0) begin
        x = x - ys; y = y - xs; z = z + a;
      end else begin
        x = x + ys; y = y + xs; z = z - a;
      end
    end
    e.x = x; e.y = y; e.z = z; e.tag = tag;
    return e;
  endfunction

  task automatic send(input logic [19:0] x, input logic [19:0] y, input logic [19:0] z, input string tag);
    int n;
    n = 0;
    Xin = x; Yin = y; Zin = z;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) chk({tag, " accept timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
    idx_log.delete();
    sb.push_back(model(x, y, z, tag));
  endtask

  task automatic collect(input int hold, output logic [19:0] rx, output logic [19:0] ry, output logic [19:0] rz);
    int   k;
    exp_t e;
    k = 1;
    out_ready = (hold == 0);
    while (!out_valid && k < 200) begin
      if (!in_ready) idx_log.push_back(int'(dut.idx));
      tick();
      k++;
    end
    rx = Xout; ry = Yout; rz = Zout;
    if (sb.size() == 0) begin
      chk("scoreboard empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, " latency"}, 32'(k), 32'd19);
    chk({e.tag, " Xout"}, 32'(Xout), 32'(e.x));
    chk({e.tag, " Yout"}, 32'(Yout), 32'(e.y));
    chk({e.tag, " Zout"}, 32'(Zout), 32'(e.z));
    chk({e.tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    for (int j = 0; j < hold; j++) begin
      in_valid = j[0];
      Xin = 20'($urandom);
      tick();
      chk({e.tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      chk({e.tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      chk({e.tag, " hold Xout"}, 32'(Xout), 32'(e.x));
      chk({e.tag, " hold Yout"}, 32'(Yout), 32'(e.y));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk({e.tag, " release out_valid"}, 32'(out_valid), 32'd0);
    chk({e.tag, " release in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    for (int i = 1; i <= 16; i++) begin
      exp_seq.push_back(i);
      if (i == 4 || i == 13) exp_seq.push_back(i);
    end

    rst = 1'b1;
    tick();
    tick();
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset Xout", 32'(Xout), 32'd0);
    chk("reset Yout", 32'(Yout), 32'd0);
    chk("reset Zout", 32'(Zout), 32'd0);
    rst = 1'b0;
    tick();

    // Unity gain vector; also logs the index sequence
    send(20'h10000, 20'h00000, 20'h00000, "gain");
    collect(0, ox, oy, oz);
    chk_tol("gain Xout vs K_h", ox, 20'h0D402, 4);
    chk_tol("gain Yout vs 0", oy, 20'h00000, 4);
    chk_tol("gain Zout vs 0", oz, 20'h00000, 2);
    chk("idx sequence length", 32'(idx_log.size()), 32'd18);
    for (int n = 0; n < 18 && n < idx_log.size(); n++)
      chk($sformatf("idx step %0d", n), 32'(idx_log[n]), 32'(exp_seq[n]));

    send(20'h1351E, 20'h00000, 20'h08000, "cosh");
    chk("back-to-back period", 32'(acc_cyc - prev_acc), 32'd20);
    collect(0, ox, oy, oz);
    chk_tol("cosh Xout", ox, 20'h120AD, 8);
    chk_tol("sinh Yout", oy, 20'h08567, 8);

    send(20'h1351E, 20'h00000, 20'hF8000, "negz");
    chk("back-to-back period 2", 32'(acc_cyc - prev_acc), 32'd20);
    collect(10, ox, oy, oz);
    chk_tol("negz Xout", ox, 20'h120AD, 8);
    chk_tol("negz Yout", oy, 20'hF7A99, 8);
    tick();
    chk("no txn from held in_valid", 32'(in_ready), 32'd1);

    for (int r = 0; r < 3; r++) begin
      send(20'($urandom_range(131072) - 65536), 20'($urandom_range(131072) - 65536),
           20'($urandom_range(117964) - 58982), $sformatf("rand%0d", r));
      collect(r, ox, oy, oz);
    end

    // Abort mid-computation and confirm a clean restart
    send(20'h10000, 20'h04000, 20'h04000, "aborted");
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort Xout", 32'(Xout), 32'd0);
    tick();
    chk("abort2 Yout", 32'(Yout), 32'd0);
    chk("abort2 Zout", 32'(Zout), 32'd0);
    rst = 1'b0;
    void'(sb.pop_back());
    tick();
    send(20'h10000, 20'h00000, 20'h04000, "after reset");
    collect(0, ox, oy, oz);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
